// File: rtl/us_ptp_pkg.sv
// Shared definitions for the ptp_sync / us_piezo_frontend pair: FSM encoding,
// time-base width and the default carrier and timing constants.
package us_ptp_pkg;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      TX     = 2'd1,
      BLANK  = 2'd2,
      LISTEN = 2'd3
   } us_state_t;

   localparam int TIME_W = 32;

   // 50 MHz system clock, 40 kHz carrier.
   localparam int DEF_HALF_PERIOD  = 625;
   localparam int DEF_BURST_CYCLES = 8;
   localparam int DEF_BLANK_CYCLES = 50000;
   localparam int DEF_RX_WINDOW    = 2500000;
   localparam int DEF_EDGE_COUNT   = 3;
   localparam int DEF_EDGE_GAP_MAX = 1500;
   localparam int DEF_SYNC_STAGES  = 2;

endpackage

// File: rtl/piezo_in_sync.sv
// Synchronizes the asynchronous comparator output and produces a registered
// one-cycle pulse on each rising edge, SYNC_STAGES+1 cycles after the pin edge.
module piezo_in_sync #(
   parameter int SYNC_STAGES = 2
)(
   input  logic clock,
   input  logic reset,
   input  logic async_in,
   output logic rise_pulse
);

   // Top bit of the chain holds the previous synchronized level for the compare.
   logic [SYNC_STAGES:0] r_chain;
   logic                 r_rise;

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         r_chain <= '0;
         r_rise  <= 1'b0;
      end else begin
         r_chain <= {r_chain[SYNC_STAGES-1:0], async_in};
         r_rise  <= r_chain[SYNC_STAGES-1] & ~r_chain[SYNC_STAGES];
      end
   end

   assign rise_pulse = r_rise;

endmodule

// File: rtl/us_piezo_frontend.sv
// Ultrasonic burst launcher and echo timestamper below ptp_sync.
// Define US_TOF_OUT_EN to add the registered time-of-flight output tof.
module us_piezo_frontend
   import us_ptp_pkg::*;
#(
   parameter int HALF_PERIOD  = DEF_HALF_PERIOD,
   parameter int BURST_CYCLES = DEF_BURST_CYCLES,
   parameter int BLANK_CYCLES = DEF_BLANK_CYCLES,
   parameter int RX_WINDOW    = DEF_RX_WINDOW,
   parameter int EDGE_COUNT   = DEF_EDGE_COUNT,
   parameter int EDGE_GAP_MAX = DEF_EDGE_GAP_MAX,
   parameter int SYNC_STAGES  = DEF_SYNC_STAGES
)(
   input  logic              clock,
   input  logic              reset,
   input  logic [TIME_W-1:0] time_cnt,
   input  logic              tx_trigger,
   input  logic              piezo_in,
   output logic              piezo_out,
   output logic              busy,
   output logic [TIME_W-1:0] tx_time,
   output logic [TIME_W-1:0] rx_time,
   output logic              rx_valid,
`ifdef US_TOF_OUT_EN
   output logic              rx_timeout,
   output logic [TIME_W-1:0] tof
`else
   output logic              rx_timeout
`endif
);

   localparam int HP_W  = $clog2(HALF_PERIOD) + 1;
   localparam int HN_W  = $clog2(2 * BURST_CYCLES) + 1;
   localparam int BL_W  = $clog2(BLANK_CYCLES) + 1;
   localparam int WIN_W = $clog2(RX_WINDOW) + 1;
   localparam int EC_W  = $clog2(EDGE_COUNT) + 1;
   localparam int GAP_W = $clog2(EDGE_GAP_MAX) + 1;

   localparam logic [HP_W-1:0]   HP_LAST  = HP_W'(HALF_PERIOD - 1);
   localparam logic [HN_W-1:0]   HN_LAST  = HN_W'(2 * BURST_CYCLES - 1);
   localparam logic [BL_W-1:0]   BL_LAST  = BL_W'(BLANK_CYCLES - 1);
   localparam logic [WIN_W-1:0]  WIN_LAST = WIN_W'(RX_WINDOW - 1);
   localparam logic [EC_W-1:0]   EC_LAST  = EC_W'(EDGE_COUNT - 1);
   localparam logic [GAP_W-1:0]  GAP_MAX  = GAP_W'(EDGE_GAP_MAX);
   localparam logic [TIME_W-1:0] LAT      = TIME_W'(SYNC_STAGES + 1);

   us_state_t         r_state;
   logic              r_piezo;
   logic              r_busy;
   logic              r_rx_valid;
   logic              r_rx_timeout;
   logic [TIME_W-1:0] r_tx_time;
   logic [TIME_W-1:0] r_rx_time;
   logic [TIME_W-1:0] r_first;
   logic [HP_W-1:0]   r_half_cnt;
   logic [HN_W-1:0]   r_half_num;
   logic [BL_W-1:0]   r_blank_cnt;
   logic [WIN_W-1:0]  r_win_cnt;
   logic [EC_W-1:0]   r_edge_cnt;
   logic [GAP_W-1:0]  r_gap_cnt;
`ifdef US_TOF_OUT_EN
   logic [TIME_W-1:0] r_tof;
`endif

   logic              w_rise;
   logic              w_detect;
   logic [TIME_W-1:0] w_stamp;
   logic [TIME_W-1:0] w_rx_comp;

   piezo_in_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
      .clock      (clock),
      .reset      (reset),
      .async_in   (piezo_in),
      .rise_pulse (w_rise)
   );

   // With EDGE_COUNT == 1 the detecting edge is also the first edge.
   assign w_stamp   = (r_edge_cnt == '0) ? time_cnt : r_first;
   assign w_rx_comp = w_stamp - LAT;
   assign w_detect  = (r_state == LISTEN) && w_rise && (r_edge_cnt == EC_LAST);

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         r_state      <= IDLE;
         r_piezo      <= 1'b0;
         r_busy       <= 1'b0;
         r_rx_valid   <= 1'b0;
         r_rx_timeout <= 1'b0;
         r_tx_time    <= '0;
         r_rx_time    <= '0;
         r_first      <= '0;
         r_half_cnt   <= '0;
         r_half_num   <= '0;
         r_blank_cnt  <= '0;
         r_win_cnt    <= '0;
         r_edge_cnt   <= '0;
         r_gap_cnt    <= '0;
`ifdef US_TOF_OUT_EN
         r_tof        <= '0;
`endif
      end else begin
         r_rx_valid   <= 1'b0;
         r_rx_timeout <= 1'b0;
         case (r_state)
            IDLE: begin
               if (tx_trigger) begin
                  r_state    <= TX;
                  r_busy     <= 1'b1;
                  r_tx_time  <= time_cnt;
                  r_piezo    <= 1'b1;
                  r_half_cnt <= '0;
                  r_half_num <= '0;
               end
            end
            TX: begin
               if (r_half_cnt == HP_LAST) begin
                  r_half_cnt <= '0;
                  if (r_half_num == HN_LAST) begin
                     r_state     <= BLANK;
                     r_piezo     <= 1'b0;
                     r_blank_cnt <= '0;
                  end else begin
                     r_half_num <= r_half_num + HN_W'(1);
                     r_piezo    <= ~r_piezo;
                  end
               end else begin
                  r_half_cnt <= r_half_cnt + HP_W'(1);
               end
            end
            BLANK: begin
               r_edge_cnt <= '0;
               if (r_blank_cnt == BL_LAST) begin
                  r_state   <= LISTEN;
                  r_win_cnt <= '0;
                  r_gap_cnt <= '0;
               end else begin
                  r_blank_cnt <= r_blank_cnt + BL_W'(1);
               end
            end
            LISTEN: begin
               r_win_cnt <= r_win_cnt + WIN_W'(1);
               if (w_detect) begin
                  r_rx_time  <= w_rx_comp;
                  r_rx_valid <= 1'b1;
`ifdef US_TOF_OUT_EN
                  r_tof      <= w_rx_comp - r_tx_time;
`endif
                  r_state    <= IDLE;
                  r_busy     <= 1'b0;
                  r_edge_cnt <= '0;
               end else begin
                  if (w_rise) begin
                     if (r_edge_cnt == '0) r_first <= time_cnt;
                     r_edge_cnt <= r_edge_cnt + EC_W'(1);
                     r_gap_cnt  <= GAP_W'(1);
                  end else if (r_edge_cnt != '0) begin
                     // Next cycle would put the following edge beyond EDGE_GAP_MAX.
                     if (r_gap_cnt == GAP_MAX) r_edge_cnt <= '0;
                     else r_gap_cnt <= r_gap_cnt + GAP_W'(1);
                  end
                  if (r_win_cnt == WIN_LAST) begin
                     r_rx_timeout <= 1'b1;
                     r_state      <= IDLE;
                     r_busy       <= 1'b0;
                     r_edge_cnt   <= '0;
                  end
               end
            end
            default: begin
               r_state <= IDLE;
               r_busy  <= 1'b0;
               r_piezo <= 1'b0;
            end
         endcase
      end
   end

   assign piezo_out  = r_piezo;
   assign busy       = r_busy;
   assign tx_time    = r_tx_time;
   assign rx_time    = r_rx_time;
   assign rx_valid   = r_rx_valid;
   assign rx_timeout = r_rx_timeout;
`ifdef US_TOF_OUT_EN
   assign tof        = r_tof;
`endif

endmodule

// File: tb/tb_us_piezo_frontend.sv
// Self-checking bench for us_piezo_frontend with small timing parameters;
// covers burst shape, detection, gap rejection, blanking, timeout, wrap and reset.
module tb_us_piezo_frontend;

   localparam int T_HP  = 4;
   localparam int T_BC  = 2;
   localparam int T_BL  = 20;
   localparam int T_RW  = 200;
   localparam int T_EC  = 3;
   localparam int T_GAP = 16;
   localparam int T_SS  = 2;
   localparam int BURST_LEN = 2 * T_HP * T_BC;
   localparam int L_IDX     = BURST_LEN + T_BL;
   localparam int TO_IDX    = L_IDX + T_RW;

   logic        clock;
   logic        reset;
   logic [31:0] time_cnt;
   logic        tx_trigger;
   logic        piezo_in;
   logic        piezo_out;
   logic        busy;
   logic [31:0] tx_time;
   logic [31:0] rx_time;
   logic        rx_valid;
   logic        rx_timeout;
`ifdef US_TOF_OUT_EN
   logic [31:0] tof;
   logic [31:0] tof_q[$];
   logic [31:0] last_tof;
`endif

   logic [31:0] exp_q[$];
   logic [31:0] last_rx;
   logic [31:0] mon_exp;
   int          n_checks;
   int          n_errors;
   int          n_valid;
   int          n_timeout;

   us_piezo_frontend #(
      .HALF_PERIOD  (T_HP),
      .BURST_CYCLES (T_BC),
      .BLANK_CYCLES (T_BL),
      .RX_WINDOW    (T_RW),
      .EDGE_COUNT   (T_EC),
      .EDGE_GAP_MAX (T_GAP),
      .SYNC_STAGES  (T_SS)
   ) dut (
      .clock      (clock),
      .reset      (reset),
      .time_cnt   (time_cnt),
      .tx_trigger (tx_trigger),
      .piezo_in   (piezo_in),
      .piezo_out  (piezo_out),
      .busy       (busy),
      .tx_time    (tx_time),
      .rx_time    (rx_time),
      .rx_valid   (rx_valid),
`ifdef US_TOF_OUT_EN
      .rx_timeout (rx_timeout),
      .tof        (tof)
`else
      .rx_timeout (rx_timeout)
`endif
   );

   // ---------------- clock / reset ----------------
   initial clock = 1'b0;
   always #5 clock = ~clock;

   // ---------------- driver tasks ----------------
   task automatic tick();
      @(posedge clock);
      #1;
      time_cnt = time_cnt + 32'd1;
   endtask

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
      end
   endtask

   function automatic logic burst_bit(input int idx);
      return (idx < BURST_LEN) && (((idx / T_HP) % 2) == 0);
   endfunction

   // ---------------- scoreboard ----------------
   always @(negedge clock) begin
      if (!reset) begin
         if (rx_valid) begin
            n_valid++;
            if (exp_q.size() == 0) begin
               chk("unexpected_rx_valid", 32'd1, 32'd0);
            end else begin
               mon_exp = exp_q.pop_front();
               chk("rx_time", rx_time, mon_exp);
`ifdef US_TOF_OUT_EN
               mon_exp = tof_q.pop_front();
               chk("tof", tof, mon_exp);
`endif
            end
         end
         if (rx_timeout) n_timeout++;
      end
   end

   // ---------------- vector table ----------------
   typedef struct {
      logic [31:0]      trig;
      bit               tc_set;
      logic [31:0]      tc_val;
      int               n_edges;
      logic [4:0][31:0] edges;
      bit               exp_valid;
      logic [31:0]      exp_rx;
   } vec_t;

   vec_t vecs[9];

   function automatic vec_t mk(input logic [31:0] trig, input bit tc_set, input logic [31:0] tc_val,
                               input int n, input logic [31:0] e0, input logic [31:0] e1,
                               input logic [31:0] e2, input logic [31:0] e3, input logic [31:0] e4,
                               input bit v, input logic [31:0] rx);
      vec_t r;
      r.trig = trig;  r.tc_set = tc_set;  r.tc_val = tc_val;  r.n_edges = n;
      r.edges[0] = e0;  r.edges[1] = e1;  r.edges[2] = e2;  r.edges[3] = e3;  r.edges[4] = e4;
      r.exp_valid = v;  r.exp_rx = rx;
      return r;
   endfunction

   task automatic run_vec(input vec_t v);
      int idx;
      int to_idx;
      int nv0;
      int nt0;
      bit done;
      logic [31:0] valid_tc;
      nv0 = n_valid;
      nt0 = n_timeout;
      valid_tc = 32'hdead_beef;
      to_idx = -1;
      if (v.exp_valid) begin
         exp_q.push_back(v.exp_rx);
`ifdef US_TOF_OUT_EN
         tof_q.push_back(v.exp_rx - v.trig);
         last_tof = v.exp_rx - v.trig;
`endif
         last_rx = v.exp_rx;
      end
      time_cnt   = v.trig;
      tx_trigger = 1'b1;
      tick();
      tx_trigger = 1'b0;
      idx  = 0;
      done = 1'b0;
      while (!done) begin
         if (idx == L_IDX && v.tc_set) time_cnt = v.tc_val;
         for (int i = 0; i < v.n_edges; i++) begin
            if (time_cnt == v.edges[i]) piezo_in = 1'b1;
            if (time_cnt == v.edges[i] + 32'd4) piezo_in = 1'b0;
         end
         if (idx < BURST_LEN + 2) chk("burst_shape", {31'd0, piezo_out}, {31'd0, burst_bit(idx)});
         tick();
         idx++;
         if (rx_valid) valid_tc = time_cnt;
         if (rx_timeout) to_idx = idx;
         if (!busy) done = 1'b1;
         if (idx > TO_IDX + 20) begin
            chk("busy_never_cleared", {31'd0, busy}, 32'd0);
            done = 1'b1;
         end
      end
      piezo_in = 1'b0;
      for (int i = 0; i < 5; i++) tick();
      chk("tx_time", tx_time, v.trig);
      chk("rx_time_held", rx_time, last_rx);
      chk("valid_count", n_valid - nv0, v.exp_valid ? 32'd1 : 32'd0);
      chk("timeout_count", n_timeout - nt0, v.exp_valid ? 32'd0 : 32'd1);
      if (v.exp_valid) chk("detect_latency", valid_tc, v.edges[v.n_edges-1] + 32'd4);
      else chk("timeout_index", to_idx, TO_IDX);
`ifdef US_TOF_OUT_EN
      chk("tof_held", tof, last_tof);
`endif
   endtask

   // ---------------- main sequence ----------------
   initial begin
      int nv0;
      int nt0;
      n_checks = 0;  n_errors = 0;  n_valid = 0;  n_timeout = 0;
      last_rx = 32'd0;
`ifdef US_TOF_OUT_EN
      last_tof = 32'd0;
`endif
      reset = 1'b1;  time_cnt = 32'd0;  tx_trigger = 1'b0;  piezo_in = 1'b0;

      //              trig          set  tc_val  n  e0           e1    e2    e3    e4    v  rx
      vecs[0] = mk(32'd100,        0, 32'd0,  3, 300,         308,  316,  0,    0,    1, 32'd300);
      vecs[1] = mk(32'd150,        0, 32'd0,  5, 300,         320,  340,  348,  356,  1, 32'd340);
      vecs[2] = mk(32'd100,        0, 32'd0,  3, 250,         266,  282,  0,    0,    1, 32'd250);
      vecs[3] = mk(32'd100,        0, 32'd0,  3, 250,         267,  284,  0,    0,    0, 32'd0);
      vecs[4] = mk(32'd100,        0, 32'd0,  3, 118,         124,  130,  0,    0,    0, 32'd0);
      vecs[5] = mk(32'hFFFFFFD0,   0, 32'd0,  3, 32'hFFFFFFFF, 7,   15,   0,    0,    1, 32'hFFFFFFFF);
      vecs[6] = mk(32'hFFFFFFF0,   1, 32'd8,  3, 32'h10,      32'h18, 32'h20, 0,  0,    1, 32'h10);
      vecs[7] = mk(32'd100,        0, 32'd0,  3, 317,         325,  333,  0,    0,    1, 32'd317);
      vecs[8] = mk(32'd100,        0, 32'd0,  3, 318,         326,  334,  0,    0,    0, 32'd0);

      #22 reset = 1'b0;
      tick();
      chk("reset_piezo_out", {31'd0, piezo_out}, 32'd0);
      chk("reset_busy", {31'd0, busy}, 32'd0);
      chk("reset_tx_time", tx_time, 32'd0);
      chk("reset_rx_time", rx_time, 32'd0);
      chk("reset_pulses", {30'd0, rx_valid, rx_timeout}, 32'd0);
`ifdef US_TOF_OUT_EN
      chk("reset_tof", tof, 32'd0);
`endif

      for (int k = 0; k < 9; k++) run_vec(vecs[k]);

      // Second trigger mid-burst is ignored; trigger on the return-to-IDLE cycle too.
      nt0 = n_timeout;
      nv0 = n_valid;
      time_cnt = 32'd500;
      tx_trigger = 1'b1;
      tick();
      tx_trigger = 1'b0;
      for (int i = 0; i < 6; i++) tick();
      tx_trigger = 1'b1;
      tick();
      tx_trigger = 1'b0;
      chk("retrigger_tx_time", tx_time, 32'd500);
      chk("retrigger_busy", {31'd0, busy}, 32'd1);
      chk("retrigger_piezo", {31'd0, piezo_out}, {31'd0, burst_bit(7)});
      for (int i = 7; i < TO_IDX - 1; i++) tick();
      tx_trigger = 1'b1;
      tick();
      tx_trigger = 1'b0;
      chk("timeout_pulse", {31'd0, rx_timeout}, 32'd1);
      chk("busy_after_timeout", {31'd0, busy}, 32'd0);
      tick();
      chk("trigger_at_return_ignored", {31'd0, busy}, 32'd0);
      chk("retrigger_timeout_count", n_timeout - nt0, 32'd1);
      chk("retrigger_valid_count", n_valid - nv0, 32'd0);

      // Reset mid-burst.
      time_cnt = 32'd700;
      tx_trigger = 1'b1;
      tick();
      tx_trigger = 1'b0;
      tick();
      tick();
      chk("pre_reset_piezo", {31'd0, piezo_out}, 32'd1);
      #2 reset = 1'b1;
      #1;
      last_rx = 32'd0;
      chk("async_reset_piezo", {31'd0, piezo_out}, 32'd0);
      chk("async_reset_busy", {31'd0, busy}, 32'd0);
      chk("async_reset_tx_time", tx_time, 32'd0);
      chk("async_reset_rx_time", rx_time, last_rx);
`ifdef US_TOF_OUT_EN
      chk("async_reset_tof", tof, 32'd0);
`endif
      #3 reset = 1'b0;
      nt0 = n_timeout;
      nv0 = n_valid;
      for (int i = 0; i < TO_IDX + 40; i++) begin
         piezo_in = ((i % 8) < 4) && (i < 64);
         tick();
      end
      piezo_in = 1'b0;
      chk("post_reset_no_valid", n_valid - nv0, 32'd0);
      chk("post_reset_no_timeout", n_timeout - nt0, 32'd0);
      chk("post_reset_idle", {31'd0, busy}, 32'd0);

      chk("exp_q_drained", exp_q.size(), 32'd0);
      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
